// File: rtl/button_debounce_if.sv
// rtl/button_debounce_if.sv - button conditioning bus between pins, debouncer and register block
//
// Purpose: bundles the raw pin inputs, the conditioned outputs and the
// event clear strobe of button_debounce into one interface.
// Optional macro: BUTTON_DEBOUNCE_IRQ_EN adds irq_mask_i / irq_o.
// Signals:
//   btn_raw_i   raw asynchronous button pins
//   event_clr_i write-1-to-clear strobe for event_o
//   btn_o       debounced level, 1 = pressed
//   press_o     one-cycle pulse on accepted press
//   release_o   one-cycle pulse on accepted release
//   event_o     sticky press flags
//   irq_mask_i  per-button interrupt enable (IRQ build only)
//   irq_o       level interrupt (IRQ build only)
// Modports: slave = debouncer side, master = pins/register-block side.

interface button_debounce_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw_i;
  logic [N_BTN-1:0] event_clr_i;
  logic [N_BTN-1:0] btn_o;
  logic [N_BTN-1:0] press_o;
  logic [N_BTN-1:0] release_o;
  logic [N_BTN-1:0] event_o;
`ifdef BUTTON_DEBOUNCE_IRQ_EN
  logic [N_BTN-1:0] irq_mask_i;
  logic             irq_o;

  modport slave (
    input  btn_raw_i, event_clr_i, irq_mask_i,
    output btn_o, press_o, release_o, event_o, irq_o
  );
  modport master (
    output btn_raw_i, event_clr_i, irq_mask_i,
    input  btn_o, press_o, release_o, event_o, irq_o
  );
`else
  modport slave (
    input  btn_raw_i, event_clr_i,
    output btn_o, press_o, release_o, event_o
  );
  modport master (
    output btn_raw_i, event_clr_i,
    input  btn_o, press_o, release_o, event_o
  );
`endif
endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchroniser, per-button debounce FSM, press/release pulses, sticky events
//
// Purpose: conditions raw push-buttons for the LED/GPIO register block.
// Optional macro: BUTTON_DEBOUNCE_IRQ_EN adds a masked, registered level IRQ.
// Ports:
//   clk    system clock
//   reset  synchronous active-low reset
//   bus    button_debounce_if.slave (raw pins in, conditioned levels/pulses/events out)
// Parameters:
//   N_BTN      number of buttons
//   DB_CYCLES  consecutive stable cycles to accept a new level (1..2^24-1)
//   ACTIVE_LOW 1 = raw pin reads 0 when pressed

module button_debounce #(
  parameter int N_BTN      = 4,
  parameter int DB_CYCLES  = 500000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic              clk,
  input logic              reset,
  button_debounce_if.slave bus
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  // Raw value of a released button; also the synchroniser reset value so a
  // button held through reset is seen as a fresh press afterwards.
  localparam logic [N_BTN-1:0] IDLE_RAW = {N_BTN{ACTIVE_LOW}};

  typedef enum logic {ST_STABLE, ST_SETTLING} state_t;

  logic [N_BTN-1:0] sync1, sync2, s;
  logic [N_BTN-1:0] btn_q, btn_nxt;
  logic [N_BTN-1:0] press_q, release_q, event_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= IDLE_RAW;
      sync2 <= IDLE_RAW;
    end else begin
      sync1 <= bus.btn_raw_i;
      sync2 <= sync1;
    end
  end

  // 1 = pressed, independent of pin polarity.
  assign s = sync2 ^ IDLE_RAW;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          lvl_nxt;

    always_ff @(posedge clk) begin
      if (!reset) begin
        state <= ST_STABLE;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      lvl_nxt   = btn_q[i];
      case (state)
        ST_STABLE: begin
          if (s[i] != btn_q[i]) begin
            if (DB_CYCLES == 1) begin
              // Single-cycle filter: accept immediately, never settle.
              lvl_nxt = s[i];
              cnt_nxt = '0;
            end else begin
              cnt_nxt   = CW'(1);
              state_nxt = ST_SETTLING;
            end
          end else begin
            cnt_nxt = '0;
          end
        end
        ST_SETTLING: begin
          if (s[i] == btn_q[i]) begin
            cnt_nxt   = '0;
            state_nxt = ST_STABLE;
          end else if (cnt == CW'(DB_CYCLES - 1)) begin
            lvl_nxt   = s[i];
            cnt_nxt   = '0;
            state_nxt = ST_STABLE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = ST_STABLE;
        end
      endcase
    end

    assign btn_nxt[i] = lvl_nxt;
  end

  // Pulses are registered alongside btn_q so they coincide with the new level.
  // The event flag samples the registered pulse; a set in the same cycle as a
  // clear strobe wins so no press is lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      event_q   <= '0;
    end else begin
      btn_q     <= btn_nxt;
      press_q   <= btn_nxt & ~btn_q;
      release_q <= ~btn_nxt & btn_q;
      event_q   <= (event_q & ~bus.event_clr_i) | press_q;
    end
  end

  assign bus.btn_o     = btn_q;
  assign bus.press_o   = press_q;
  assign bus.release_o = release_q;
  assign bus.event_o   = event_q;

`ifdef BUTTON_DEBOUNCE_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= |(event_q & bus.irq_mask_i);
  end

  assign bus.irq_o = irq_q;
`endif

endmodule
